cgra_fabric: RTL and testbench
==============================

// Module: cgra_fabric
// PURPOSE
//  Small coarse-grained reconfigurable array top: 8 lanes, each with a 64x32 local memory loaded by its own host port.
//  Per cycle, each lane combines one memory word with a selectable io_in operand; 12 configurable output muxes route results to io_out.
//  Programmed through a flat config bus; sits between host DMA and streaming I/O fabric.
// PARAMETERS
//  DW 32 datapath width;  AW 18 config address width;  NLANE 8 lanes/host ports;  NIO 12 stream I/O ports;  MEMD 64 words per lane memory
// PORTS
//  clock                          in  1   single clock, all state on posedge
//  reset                          in  1   synchronous, active-high
//  io_cfg_en                      in  1   config write strobe
//  io_cfg_addr                    in  18  config register address
//  io_cfg_data                    in  32  config write data
//  io_hostInterface_k_write_addr        in  6   k=0..7; lane-k memory write address
//  io_hostInterface_k_write_data_valid  in  1   host write request
//  io_hostInterface_k_write_data_ready  out 1   write accepted when valid&ready
//  io_hostInterface_k_write_data_bits   in  32  write data
//  io_hostInterface_k_cycle             in  3   lane start offset, latched with each accepted write
//  io_hostInterface_k_read_addr         in  6   readback address
//  io_hostInterface_k_read_data_ready   in  1   readback request
//  io_hostInterface_k_read_data_valid   out 1   readback data valid
//  io_hostInterface_k_read_data_bits    out 32  readback data
//  io_en_k                        in  1   k=0..7; lane run enable
//  io_in_j / io_out_j             in/out 32  j=0..11; stream operands / routed results
// BEHAVIOUR
//  Reset: all config regs, lane ptr/result/start counters, io_out, read_data_valid/bits -> 0; write_data_ready=0 during reset, 1 otherwise. Memories not cleared.
//  Config: cfg_en=1 writes reg io_cfg_addr[4:0] when io_cfg_addr[17:5]==0; else ignored. Regs 20..31 read-as-ignored.
//   Reg k (0..7) lane ctl: [1:0] op (0 pass MEM, 1 MEM+opnd, 2 low32(MEM*opnd), 3 MEM^opnd); [7:2] base; [13:8] len (0=>64); [17:14] opnd src (0..11 io_in_j, 12..15 => 0).
//   Reg 8+j (j=0..11) out mux: [2:0] lane index; [3] enable (0 => io_out_j=0).
//   Config write to reg k reloads lane k ptr=base, start counter=latched cycle.
//  Host write: valid&ready -> MEM_k[write_addr]<=bits next edge; cycle latched as start offset. Same-cycle lane read sees old data.
//  Lane run (io_en_k=1): start counter nonzero -> decrement, nothing else. Else res_k<=op(MEM_k[ptr],opnd) (async mem read), ptr<=ptr+1, wrap to base after len words (mod 64 address wrap).
//  io_en_k=0: ptr, counter, res_k hold. Latency: operand/memory sampled at edge, res visible 1 cycle later.
//  io_out_j registered: io_out_j<=en ? res_{sel} : 0; total io_in->io_out latency 2 cycles.
//  Arithmetic: unsigned, 32-bit truncating, no saturation/flags.
//  io_out may be looped to io_in externally; no combinational in->out path (loop-safe).
//  Reset mid-run overrides everything, including a same-cycle config or host write.
// CONFIGURATION
//  CGRA_READBACK_EN defined: read_data_ready=1 -> next cycle read_data_valid=1, bits=MEM_k[read_addr] (sampled at request edge), one word per cycle.
//  Not defined: read_data_valid=0, read_data_bits=0 constantly; read ports ignored.
// TESTING
//  Reset 20 cycles -> all io_out=0, write_data_ready=0 then 1 after reset drops.
//  Host writes 1 at addr1 lane5, cycle=0; reg5={src=12,len=1,base=1,op=0}; reg8={en,lane5}; io_en_5=1 -> io_out_0=1 two cycles later, steady.
//  Lane1 cycle=2 start -> result delayed exactly 2 extra enabled cycles vs lane with cycle=0.
//  MEM_3[0..2]=1,2,3, len=3, op=add opnd io_in_0=10 -> res 11,12,13,11 wrap.
//  op=mul MEM=0x10000, opnd 0x10000 -> 0 (truncation); cfg write with addr[17:5]!=0 -> no change.
//  With CGRA_READBACK_EN: read addr1 lane5 -> valid=1, bits=1 next cycle; without: valid stays 0.

Source files
------------

// File: rtl/cgra_fabric.sv
// cgra_fabric: 8-lane coarse-grained reconfigurable array with per-lane local memories and 12 routed outputs.
// Optional macro CGRA_READBACK_EN enables host readback of lane memories.
module cgra_fabric #(
  parameter int DW    = 32,
  parameter int AW    = 18,
  parameter int NLANE = 8,
  parameter int NIO   = 12,
  parameter int MEMD  = 64
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          io_cfg_en,
  input  logic [AW-1:0] io_cfg_addr,
  input  logic [DW-1:0] io_cfg_data,
  input  logic [5:0]    io_hostInterface_0_write_addr, io_hostInterface_0_read_addr,
  input  logic          io_hostInterface_0_write_data_valid, io_hostInterface_0_read_data_ready,
  input  logic [DW-1:0] io_hostInterface_0_write_data_bits,
  input  logic [2:0]    io_hostInterface_0_cycle,
  output logic          io_hostInterface_0_write_data_ready, io_hostInterface_0_read_data_valid,
  output logic [DW-1:0] io_hostInterface_0_read_data_bits,
  input  logic [5:0]    io_hostInterface_1_write_addr, io_hostInterface_1_read_addr,
  input  logic          io_hostInterface_1_write_data_valid, io_hostInterface_1_read_data_ready,
  input  logic [DW-1:0] io_hostInterface_1_write_data_bits,
  input  logic [2:0]    io_hostInterface_1_cycle,
  output logic          io_hostInterface_1_write_data_ready, io_hostInterface_1_read_data_valid,
  output logic [DW-1:0] io_hostInterface_1_read_data_bits,
  input  logic [5:0]    io_hostInterface_2_write_addr, io_hostInterface_2_read_addr,
  input  logic          io_hostInterface_2_write_data_valid, io_hostInterface_2_read_data_ready,
  input  logic [DW-1:0] io_hostInterface_2_write_data_bits,
  input  logic [2:0]    io_hostInterface_2_cycle,
  output logic          io_hostInterface_2_write_data_ready, io_hostInterface_2_read_data_valid,
  output logic [DW-1:0] io_hostInterface_2_read_data_bits,
  input  logic [5:0]    io_hostInterface_3_write_addr, io_hostInterface_3_read_addr,
  input  logic          io_hostInterface_3_write_data_valid, io_hostInterface_3_read_data_ready,
  input  logic [DW-1:0] io_hostInterface_3_write_data_bits,
  input  logic [2:0]    io_hostInterface_3_cycle,
  output logic          io_hostInterface_3_write_data_ready, io_hostInterface_3_read_data_valid,
  output logic [DW-1:0] io_hostInterface_3_read_data_bits,
  input  logic [5:0]    io_hostInterface_4_write_addr, io_hostInterface_4_read_addr,
  input  logic          io_hostInterface_4_write_data_valid, io_hostInterface_4_read_data_ready,
  input  logic [DW-1:0] io_hostInterface_4_write_data_bits,
  input  logic [2:0]    io_hostInterface_4_cycle,
  output logic          io_hostInterface_4_write_data_ready, io_hostInterface_4_read_data_valid,
  output logic [DW-1:0] io_hostInterface_4_read_data_bits,
  input  logic [5:0]    io_hostInterface_5_write_addr, io_hostInterface_5_read_addr,
  input  logic          io_hostInterface_5_write_data_valid, io_hostInterface_5_read_data_ready,
  input  logic [DW-1:0] io_hostInterface_5_write_data_bits,
  input  logic [2:0]    io_hostInterface_5_cycle,
  output logic          io_hostInterface_5_write_data_ready, io_hostInterface_5_read_data_valid,
  output logic [DW-1:0] io_hostInterface_5_read_data_bits,
  input  logic [5:0]    io_hostInterface_6_write_addr, io_hostInterface_6_read_addr,
  input  logic          io_hostInterface_6_write_data_valid, io_hostInterface_6_read_data_ready,
  input  logic [DW-1:0] io_hostInterface_6_write_data_bits,
  input  logic [2:0]    io_hostInterface_6_cycle,
  output logic          io_hostInterface_6_write_data_ready, io_hostInterface_6_read_data_valid,
  output logic [DW-1:0] io_hostInterface_6_read_data_bits,
  input  logic [5:0]    io_hostInterface_7_write_addr, io_hostInterface_7_read_addr,
  input  logic          io_hostInterface_7_write_data_valid, io_hostInterface_7_read_data_ready,
  input  logic [DW-1:0] io_hostInterface_7_write_data_bits,
  input  logic [2:0]    io_hostInterface_7_cycle,
  output logic          io_hostInterface_7_write_data_ready, io_hostInterface_7_read_data_valid,
  output logic [DW-1:0] io_hostInterface_7_read_data_bits,
  input  logic          io_en_0, io_en_1, io_en_2, io_en_3, io_en_4, io_en_5, io_en_6, io_en_7,
  input  logic [DW-1:0] io_in_0, io_in_1, io_in_2, io_in_3, io_in_4, io_in_5,
  input  logic [DW-1:0] io_in_6, io_in_7, io_in_8, io_in_9, io_in_10, io_in_11,
  output logic [DW-1:0] io_out_0, io_out_1, io_out_2, io_out_3, io_out_4, io_out_5,
  output logic [DW-1:0] io_out_6, io_out_7, io_out_8, io_out_9, io_out_10, io_out_11
);

  logic [NLANE-1:0][5:0]    wr_addr_s, rd_addr_s, ptr_r, ptr_nxt_s, off_s;
  logic [NLANE-1:0]         wr_valid_s, wr_ready_s, wr_fire_s, rd_req_s, en_s, rd_valid_s, cfg_lane_hit_s;
  logic [NLANE-1:0][DW-1:0] wr_bits_s, rd_bits_s, res_r, opnd_s, mem_word_s, alu_s;
  logic [NLANE-1:0][2:0]    cycle_s, cnt_r, cyc_r;
  logic [NLANE-1:0][6:0]    len_s;
  logic [NLANE-1:0][17:0]   lane_cfg_r;
  logic [NIO-1:0][3:0]      mux_cfg_r;
  logic [NIO-1:0][DW-1:0]   io_in_s, out_r;
  logic [DW-1:0]            mem_r [NLANE][MEMD];
  logic                     cfg_hit_s;
  logic [4:0]               cfg_idx_s;
  logic [3:0]               mux_idx_s;
  logic                     unused_cfg_s;

  function automatic logic [DW-1:0] lane_op(input logic [1:0] op, input logic [DW-1:0] m,
                                            input logic [DW-1:0] o);
    case (op)
      2'd0:    lane_op = m;
      2'd1:    lane_op = m + o;
      2'd2:    lane_op = m * o;
      2'd3:    lane_op = m ^ o;
      default: lane_op = m;
    endcase
  endfunction

  assign wr_addr_s  = {io_hostInterface_7_write_addr, io_hostInterface_6_write_addr, io_hostInterface_5_write_addr,
                       io_hostInterface_4_write_addr, io_hostInterface_3_write_addr, io_hostInterface_2_write_addr,
                       io_hostInterface_1_write_addr, io_hostInterface_0_write_addr};
  assign rd_addr_s  = {io_hostInterface_7_read_addr, io_hostInterface_6_read_addr, io_hostInterface_5_read_addr,
                       io_hostInterface_4_read_addr, io_hostInterface_3_read_addr, io_hostInterface_2_read_addr,
                       io_hostInterface_1_read_addr, io_hostInterface_0_read_addr};
  assign wr_valid_s = {io_hostInterface_7_write_data_valid, io_hostInterface_6_write_data_valid,
                       io_hostInterface_5_write_data_valid, io_hostInterface_4_write_data_valid,
                       io_hostInterface_3_write_data_valid, io_hostInterface_2_write_data_valid,
                       io_hostInterface_1_write_data_valid, io_hostInterface_0_write_data_valid};
  assign rd_req_s   = {io_hostInterface_7_read_data_ready, io_hostInterface_6_read_data_ready,
                       io_hostInterface_5_read_data_ready, io_hostInterface_4_read_data_ready,
                       io_hostInterface_3_read_data_ready, io_hostInterface_2_read_data_ready,
                       io_hostInterface_1_read_data_ready, io_hostInterface_0_read_data_ready};
  assign wr_bits_s  = {io_hostInterface_7_write_data_bits, io_hostInterface_6_write_data_bits,
                       io_hostInterface_5_write_data_bits, io_hostInterface_4_write_data_bits,
                       io_hostInterface_3_write_data_bits, io_hostInterface_2_write_data_bits,
                       io_hostInterface_1_write_data_bits, io_hostInterface_0_write_data_bits};
  assign cycle_s    = {io_hostInterface_7_cycle, io_hostInterface_6_cycle, io_hostInterface_5_cycle,
                       io_hostInterface_4_cycle, io_hostInterface_3_cycle, io_hostInterface_2_cycle,
                       io_hostInterface_1_cycle, io_hostInterface_0_cycle};
  assign en_s       = {io_en_7, io_en_6, io_en_5, io_en_4, io_en_3, io_en_2, io_en_1, io_en_0};
  assign io_in_s    = {io_in_11, io_in_10, io_in_9, io_in_8, io_in_7, io_in_6,
                       io_in_5, io_in_4, io_in_3, io_in_2, io_in_1, io_in_0};

  assign {io_hostInterface_7_write_data_ready, io_hostInterface_6_write_data_ready,
          io_hostInterface_5_write_data_ready, io_hostInterface_4_write_data_ready,
          io_hostInterface_3_write_data_ready, io_hostInterface_2_write_data_ready,
          io_hostInterface_1_write_data_ready, io_hostInterface_0_write_data_ready} = wr_ready_s;
  assign {io_hostInterface_7_read_data_valid, io_hostInterface_6_read_data_valid,
          io_hostInterface_5_read_data_valid, io_hostInterface_4_read_data_valid,
          io_hostInterface_3_read_data_valid, io_hostInterface_2_read_data_valid,
          io_hostInterface_1_read_data_valid, io_hostInterface_0_read_data_valid} = rd_valid_s;
  assign {io_hostInterface_7_read_data_bits, io_hostInterface_6_read_data_bits,
          io_hostInterface_5_read_data_bits, io_hostInterface_4_read_data_bits,
          io_hostInterface_3_read_data_bits, io_hostInterface_2_read_data_bits,
          io_hostInterface_1_read_data_bits, io_hostInterface_0_read_data_bits} = rd_bits_s;
  assign {io_out_11, io_out_10, io_out_9, io_out_8, io_out_7, io_out_6,
          io_out_5, io_out_4, io_out_3, io_out_2, io_out_1, io_out_0} = out_r;

  // Host writes are refused only while reset is held.
  assign wr_ready_s   = {NLANE{~reset}};
  assign wr_fire_s    = wr_valid_s & wr_ready_s;
  assign cfg_hit_s    = io_cfg_en && (io_cfg_addr[AW-1:5] == {(AW-5){1'b0}});
  assign cfg_idx_s    = io_cfg_addr[4:0];
  // Regs 8..19 fold onto mux slots 0..11 modulo 16.
  assign mux_idx_s    = cfg_idx_s[3:0] - 4'd8;
  assign unused_cfg_s = ^io_cfg_data[DW-1:18];

  // Lane operand select, ALU and pointer-advance logic.
  always_comb begin
    cfg_lane_hit_s = '0;
    opnd_s         = '0;
    mem_word_s     = '0;
    alu_s          = '0;
    off_s          = '0;
    len_s          = '0;
    ptr_nxt_s      = '0;
    if (cfg_hit_s && (cfg_idx_s[4:3] == 2'd0)) begin
      cfg_lane_hit_s[cfg_idx_s[2:0]] = 1'b1;
    end else begin
      cfg_lane_hit_s = '0;
    end
    for (int k = 0; k < NLANE; k++) begin
      if (lane_cfg_r[k][17:14] < 4'd12) begin
        opnd_s[k] = io_in_s[lane_cfg_r[k][17:14]];
      end else begin
        opnd_s[k] = '0;
      end
      mem_word_s[k] = mem_r[k][ptr_r[k]];
      alu_s[k]      = lane_op(lane_cfg_r[k][1:0], mem_word_s[k], opnd_s[k]);
      off_s[k]      = ptr_r[k] - lane_cfg_r[k][7:2];
      len_s[k]      = (lane_cfg_r[k][13:8] == 6'd0) ? 7'd64 : {1'b0, lane_cfg_r[k][13:8]};
      if (({1'b0, off_s[k]} + 7'd1) >= len_s[k]) begin
        ptr_nxt_s[k] = lane_cfg_r[k][7:2];
      end else begin
        ptr_nxt_s[k] = ptr_r[k] + 6'd1;
      end
    end
  end

  // Configuration register file.
  always_ff @(posedge clock) begin
    if (reset) begin
      lane_cfg_r <= '0;
      mux_cfg_r  <= '0;
    end else if (cfg_hit_s) begin
      if (cfg_idx_s < 5'd8) begin
        lane_cfg_r[cfg_idx_s[2:0]] <= io_cfg_data[17:0];
      end else if (cfg_idx_s < 5'd20) begin
        mux_cfg_r[mux_idx_s] <= io_cfg_data[3:0];
      end
    end
  end

  // Lane pointer, start counter and result state.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_r <= '0;
      cnt_r <= '0;
      cyc_r <= '0;
      res_r <= '0;
    end else begin
      for (int k = 0; k < NLANE; k++) begin
        if (wr_fire_s[k]) begin
          cyc_r[k] <= cycle_s[k];
        end
        // A config write restarts the lane with the previously latched offset.
        if (cfg_lane_hit_s[k]) begin
          ptr_r[k] <= io_cfg_data[7:2];
          cnt_r[k] <= cyc_r[k];
        end else if (en_s[k]) begin
          if (cnt_r[k] != 3'd0) begin
            cnt_r[k] <= cnt_r[k] - 3'd1;
          end else begin
            res_r[k] <= alu_s[k];
            ptr_r[k] <= ptr_nxt_s[k];
          end
        end
      end
    end
  end

  // Lane memories; contents survive reset.
  always_ff @(posedge clock) begin
    for (int k = 0; k < NLANE; k++) begin
      if (wr_fire_s[k]) begin
        mem_r[k][wr_addr_s[k]] <= wr_bits_s[k];
      end
    end
  end

  // Registered output crossbar.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_r <= '0;
    end else begin
      for (int j = 0; j < NIO; j++) begin
        out_r[j] <= mux_cfg_r[j][3] ? res_r[mux_cfg_r[j][2:0]] : {DW{1'b0}};
      end
    end
  end

`ifdef CGRA_READBACK_EN
  logic [NLANE-1:0]         rd_valid_r;
  logic [NLANE-1:0][DW-1:0] rd_bits_r;

  // Readback: one word per request, returned the following cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid_r <= '0;
      rd_bits_r  <= '0;
    end else begin
      for (int k = 0; k < NLANE; k++) begin
        rd_valid_r[k] <= rd_req_s[k];
        if (rd_req_s[k]) begin
          rd_bits_r[k] <= mem_r[k][rd_addr_s[k]];
        end
      end
    end
  end

  assign rd_valid_s = rd_valid_r;
  assign rd_bits_s  = rd_bits_r;
`else
  logic unused_rd_s;
  assign unused_rd_s = ^{rd_addr_s, rd_req_s};
  assign rd_valid_s  = '0;
  assign rd_bits_s   = '0;
`endif

endmodule

// File: tb/tb_cgra_fabric.sv
// Directed self-checking bench for cgra_fabric (reset, lane ops, start offsets, wrap, truncation, cfg decode, readback).
module tb_cgra_fabric;
  logic        clk_s, rst_s, cfg_en_s;
  logic [17:0] cfg_addr_s;
  logic [31:0] cfg_data_s;
  logic [5:0]  wa_s [8];
  logic [5:0]  ra_s [8];
  logic        wv_s [8];
  logic        wr_rdy_s [8];
  logic        rr_s [8];
  logic        rv_s [8];
  logic        en_s [8];
  logic [31:0] wd_s [8];
  logic [31:0] rd_s [8];
  logic [2:0]  cyc_s [8];
  logic [31:0] din_s [12];
  logic [31:0] dout_s [12];
  int          n_tests, n_fail;

  cgra_fabric dut (
    .clock(clk_s), .reset(rst_s), .io_cfg_en(cfg_en_s), .io_cfg_addr(cfg_addr_s), .io_cfg_data(cfg_data_s),
    .io_hostInterface_0_write_addr(wa_s[0]), .io_hostInterface_0_read_addr(ra_s[0]), .io_hostInterface_0_write_data_valid(wv_s[0]), .io_hostInterface_0_read_data_ready(rr_s[0]), .io_hostInterface_0_write_data_bits(wd_s[0]),
    .io_hostInterface_0_cycle(cyc_s[0]), .io_hostInterface_0_write_data_ready(wr_rdy_s[0]), .io_hostInterface_0_read_data_valid(rv_s[0]), .io_hostInterface_0_read_data_bits(rd_s[0]),
    .io_hostInterface_1_write_addr(wa_s[1]), .io_hostInterface_1_read_addr(ra_s[1]), .io_hostInterface_1_write_data_valid(wv_s[1]), .io_hostInterface_1_read_data_ready(rr_s[1]), .io_hostInterface_1_write_data_bits(wd_s[1]),
    .io_hostInterface_1_cycle(cyc_s[1]), .io_hostInterface_1_write_data_ready(wr_rdy_s[1]), .io_hostInterface_1_read_data_valid(rv_s[1]), .io_hostInterface_1_read_data_bits(rd_s[1]),
    .io_hostInterface_2_write_addr(wa_s[2]), .io_hostInterface_2_read_addr(ra_s[2]), .io_hostInterface_2_write_data_valid(wv_s[2]), .io_hostInterface_2_read_data_ready(rr_s[2]), .io_hostInterface_2_write_data_bits(wd_s[2]),
    .io_hostInterface_2_cycle(cyc_s[2]), .io_hostInterface_2_write_data_ready(wr_rdy_s[2]), .io_hostInterface_2_read_data_valid(rv_s[2]), .io_hostInterface_2_read_data_bits(rd_s[2]),
    .io_hostInterface_3_write_addr(wa_s[3]), .io_hostInterface_3_read_addr(ra_s[3]), .io_hostInterface_3_write_data_valid(wv_s[3]), .io_hostInterface_3_read_data_ready(rr_s[3]), .io_hostInterface_3_write_data_bits(wd_s[3]),
    .io_hostInterface_3_cycle(cyc_s[3]), .io_hostInterface_3_write_data_ready(wr_rdy_s[3]), .io_hostInterface_3_read_data_valid(rv_s[3]), .io_hostInterface_3_read_data_bits(rd_s[3]),
    .io_hostInterface_4_write_addr(wa_s[4]), .io_hostInterface_4_read_addr(ra_s[4]), .io_hostInterface_4_write_data_valid(wv_s[4]), .io_hostInterface_4_read_data_ready(rr_s[4]), .io_hostInterface_4_write_data_bits(wd_s[4]),
    .io_hostInterface_4_cycle(cyc_s[4]), .io_hostInterface_4_write_data_ready(wr_rdy_s[4]), .io_hostInterface_4_read_data_valid(rv_s[4]), .io_hostInterface_4_read_data_bits(rd_s[4]),
    .io_hostInterface_5_write_addr(wa_s[5]), .io_hostInterface_5_read_addr(ra_s[5]), .io_hostInterface_5_write_data_valid(wv_s[5]), .io_hostInterface_5_read_data_ready(rr_s[5]), .io_hostInterface_5_write_data_bits(wd_s[5]),
    .io_hostInterface_5_cycle(cyc_s[5]), .io_hostInterface_5_write_data_ready(wr_rdy_s[5]), .io_hostInterface_5_read_data_valid(rv_s[5]), .io_hostInterface_5_read_data_bits(rd_s[5]),
    .io_hostInterface_6_write_addr(wa_s[6]), .io_hostInterface_6_read_addr(ra_s[6]), .io_hostInterface_6_write_data_valid(wv_s[6]), .io_hostInterface_6_read_data_ready(rr_s[6]), .io_hostInterface_6_write_data_bits(wd_s[6]),
    .io_hostInterface_6_cycle(cyc_s[6]), .io_hostInterface_6_write_data_ready(wr_rdy_s[6]), .io_hostInterface_6_read_data_valid(rv_s[6]), .io_hostInterface_6_read_data_bits(rd_s[6]),
    .io_hostInterface_7_write_addr(wa_s[7]), .io_hostInterface_7_read_addr(ra_s[7]), .io_hostInterface_7_write_data_valid(wv_s[7]), .io_hostInterface_7_read_data_ready(rr_s[7]), .io_hostInterface_7_write_data_bits(wd_s[7]),
    .io_hostInterface_7_cycle(cyc_s[7]), .io_hostInterface_7_write_data_ready(wr_rdy_s[7]), .io_hostInterface_7_read_data_valid(rv_s[7]), .io_hostInterface_7_read_data_bits(rd_s[7]),
    .io_en_0(en_s[0]), .io_en_1(en_s[1]), .io_en_2(en_s[2]), .io_en_3(en_s[3]),
    .io_en_4(en_s[4]), .io_en_5(en_s[5]), .io_en_6(en_s[6]), .io_en_7(en_s[7]),
    .io_in_0(din_s[0]), .io_in_1(din_s[1]), .io_in_2(din_s[2]), .io_in_3(din_s[3]), .io_in_4(din_s[4]), .io_in_5(din_s[5]),
    .io_in_6(din_s[6]), .io_in_7(din_s[7]), .io_in_8(din_s[8]), .io_in_9(din_s[9]), .io_in_10(din_s[10]), .io_in_11(din_s[11]),
    .io_out_0(dout_s[0]), .io_out_1(dout_s[1]), .io_out_2(dout_s[2]), .io_out_3(dout_s[3]), .io_out_4(dout_s[4]), .io_out_5(dout_s[5]),
    .io_out_6(dout_s[6]), .io_out_7(dout_s[7]), .io_out_8(dout_s[8]), .io_out_9(dout_s[9]), .io_out_10(dout_s[10]), .io_out_11(dout_s[11])
  );

  // Free-running 10-unit clock.
  initial begin
    clk_s = 1'b0;
    forever #5 clk_s = ~clk_s;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_s);
    #1;
  endtask

  task automatic cfg_write(input logic [17:0] addr, input logic [31:0] data);
    cfg_en_s   = 1'b1;
    cfg_addr_s = addr;
    cfg_data_s = data;
    tick();
    cfg_en_s   = 1'b0;
  endtask

  task automatic host_write(input int lane, input logic [5:0] addr, input logic [31:0] data, input logic [2:0] cyc);
    wv_s[lane]  = 1'b1;
    wa_s[lane]  = addr;
    wd_s[lane]  = data;
    cyc_s[lane] = cyc;
    tick();
    wv_s[lane]  = 1'b0;
  endtask

  logic [31:0] add_exp [4];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    add_exp[0] = 32'd11; add_exp[1] = 32'd12; add_exp[2] = 32'd13; add_exp[3] = 32'd11;
    rst_s = 1'b1; cfg_en_s = 1'b0; cfg_addr_s = 18'd0; cfg_data_s = 32'd0;
    for (int k = 0; k < 8; k++) begin
      wa_s[k] = 6'd0; ra_s[k] = 6'd0; wv_s[k] = 1'b0; rr_s[k] = 1'b0;
      en_s[k] = 1'b0; wd_s[k] = 32'd0; cyc_s[k] = 3'd0;
    end
    for (int j = 0; j < 12; j++) din_s[j] = 32'd0;

    // Reset state
    for (int i = 0; i < 20; i++) tick();
    check("rdy_in_reset", {31'd0, wr_rdy_s[5]}, 32'd0);
    for (int j = 0; j < 12; j++) check($sformatf("out%0d_reset", j), dout_s[j], 32'd0);
    check("rv_reset", {31'd0, rv_s[5]}, 32'd0);
    rst_s = 1'b0;
    #1;
    check("rdy_after_reset", {31'd0, wr_rdy_s[5]}, 32'd1);

    // Lane 5 pass-through of MEM[1]=1 to io_out_0
    host_write(5, 6'd1, 32'd1, 3'd0);
    cfg_write(18'd5, 32'h0003_0104);
    cfg_write(18'd8, 32'h0000_000D);
    en_s[5] = 1'b1;
    tick();
    check("pass_lat1", dout_s[0], 32'd0);
    tick();
    check("pass_lat2", dout_s[0], 32'd1);
    tick();
    check("pass_steady", dout_s[0], 32'd1);

    // Start offset: lane 1 cycle=2 vs lane 2 cycle=0
    host_write(1, 6'd0, 32'd7, 3'd2);
    host_write(2, 6'd0, 32'd7, 3'd0);
    cfg_write(18'd1, 32'h0003_0100);
    cfg_write(18'd2, 32'h0003_0100);
    cfg_write(18'd9, 32'h0000_0009);
    cfg_write(18'd10, 32'h0000_000A);
    en_s[1] = 1'b1; en_s[2] = 1'b1;
    tick();
    check("l2_e1", dout_s[2], 32'd0);
    tick();
    check("l2_e2", dout_s[2], 32'd7);
    check("l1_e2", dout_s[1], 32'd0);
    tick();
    check("l1_e3", dout_s[1], 32'd0);
    tick();
    check("l1_e4", dout_s[1], 32'd7);
    en_s[1] = 1'b0; en_s[2] = 1'b0;

    // Lane 3 add with io_in_0=10 over a 3-word window, then hold
    host_write(3, 6'd0, 32'd1, 3'd0);
    host_write(3, 6'd1, 32'd2, 3'd0);
    host_write(3, 6'd2, 32'd3, 3'd0);
    cfg_write(18'd3, 32'h0000_0301);
    cfg_write(18'd11, 32'h0000_000B);
    din_s[0] = 32'd10;
    en_s[3]  = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("add_seq%0d", i), dout_s[3], add_exp[i]);
    end
    en_s[3] = 1'b0;
    tick();
    tick();
    check("add_hold", dout_s[3], 32'd12);

    // Lane 4 multiply: 0x10000*3 then truncating 0x10000*0x10000
    host_write(4, 6'd0, 32'h0001_0000, 3'd0);
    cfg_write(18'd4, 32'h0000_4102);
    cfg_write(18'd12, 32'h0000_000C);
    din_s[1] = 32'd3;
    en_s[4]  = 1'b1;
    tick();
    din_s[1] = 32'h0001_0000;
    tick();
    check("mul_small", dout_s[4], 32'h0003_0000);
    tick();
    check("mul_trunc", dout_s[4], 32'd0);
    en_s[4] = 1'b0;

    // Config decode: upper address bits must block the write
    cfg_write(18'h0_0028, 32'd0);
    cfg_write(18'h2_0008, 32'd0);
    tick();
    check("cfg_ignored", dout_s[0], 32'd1);
    cfg_write(18'd8, 32'd0);
    tick();
    check("cfg_mux_off", dout_s[0], 32'd0);

    // Readback of lane 5 address 1
    rr_s[5] = 1'b1; ra_s[5] = 6'd1;
    tick();
    rr_s[5] = 1'b0;
`ifdef CGRA_READBACK_EN
    check("rb_valid", {31'd0, rv_s[5]}, 32'd1);
    check("rb_bits", rd_s[5], 32'd1);
    tick();
    check("rb_valid_drop", {31'd0, rv_s[5]}, 32'd0);
`else
    check("rb_valid_off", {31'd0, rv_s[5]}, 32'd0);
    check("rb_bits_off", rd_s[5], 32'd0);
`endif

    // Reset mid-run overrides a same-cycle config write
    en_s[3] = 1'b1;
    rst_s = 1'b1;
    cfg_write(18'd13, 32'h0000_000B);
    check("rdy_mid_reset", {31'd0, wr_rdy_s[3]}, 32'd0);
    rst_s = 1'b0;
    tick();
    tick();
    check("out3_after_rst", dout_s[3], 32'd0);
    check("out5_after_rst", dout_s[5], 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
